// File: rtl/y86_pkg.sv
// y86_pkg -- encodings shared by the Y86 pipeline blocks (fetch, decode,
// execute and the pipeline controller).
//   icodes    : 4-bit instruction codes seen in the stage registers
//   stat_e    : 2-bit stage status
//   state_e   : pipeline controller FSM state
//   pipe_ctl_t: bundle of the seven pipeline-register control bits
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register".
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
    } pipe_ctl_t;

    // Fetch frozen and the younger stages flushed while waiting to start.
    localparam pipe_ctl_t CTL_IDLE   = pipe_ctl_t'(7'b1011100);
    // Freeze fetch and writeback, keep memory from committing anything.
    localparam pipe_ctl_t CTL_HALTED = pipe_ctl_t'(7'b1000110);

    // A stage holds an exception whenever its status is anything but AOK.
    function automatic logic is_exc(input logic [1:0] stat);
        return stat != STAT_AOK;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle between the pipeline datapath and its controller.
//   inputs to controller : start, stage icodes, decode sources, load
//                          destination, branch condition, stage status
//   outputs of controller: stall/bubble/set_cc controls, FSM state,
//                          halted flag, performance counters
// modport master: datapath side (drives hazard inputs, reads controls)
// modport slave : controller side
interface pipe_ctrl_if;

    logic        start;
    logic [3:0]  D_icode;
    logic [3:0]  E_icode;
    logic [3:0]  M_icode;
    logic [3:0]  W_icode;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_dstM;
    logic        e_Cnd;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;

    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;
    logic        W_stall;
    logic        set_cc;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cyc_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] lu_cnt;
    logic [31:0] mp_cnt;
    logic [31:0] ret_cnt;

    modport master (
        output start, D_icode, E_icode, M_icode, W_icode,
               d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
               state, halted, cyc_cnt, instr_cnt, lu_cnt, mp_cnt, ret_cnt
    );

    modport slave (
        input  start, D_icode, E_icode, M_icode, W_icode,
               d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
               state, halted, cyc_cnt, instr_cnt, lu_cnt, mp_cnt, ret_cnt
    );

endinterface

// File: rtl/sat_cnt.sv
// sat_cnt -- saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   clr : synchronous clear, dominates en
//   en  : count enable; the count sticks at all-ones instead of wrapping
//   cnt : current count
module sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: cnt_d gets its hold value first so every path assigns it and
    // no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples
    // values from before the edge.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- Y86 pipeline controller.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (returns to IDLE, clears counters)
//   bus   : pipe_ctrl_if slave -- hazard inputs in; stall/bubble/set_cc,
//           state, halted and performance counters out
// Hazard decode is purely combinational; only the FSM state and the
// counters are registered.
module pipe_ctrl
    import y86_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);

    state_e    state_q;
    state_e    state_d;
    state_e    cur_st;
    pipe_ctl_t ctl;

    logic lu;
    logic mp;
    logic rt;
    logic in_run;

    // Effective state: reset forces IDLE-looking outputs even before the
    // clearing edge, and the unused encoding behaves as IDLE.
    always_comb begin
        cur_st = ST_IDLE;
        if (rst_n) begin
            case (state_q)
                ST_RUN:    cur_st = ST_RUN;
                ST_HALTED: cur_st = ST_HALTED;
                default:   cur_st = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state_d = cur_st;
        case (cur_st)
            ST_IDLE:   if (bus.start)         state_d = ST_RUN;
            ST_RUN:    if (is_exc(bus.W_stat)) state_d = ST_HALTED;
            default:   state_d = cur_st;
        endcase
        if (!rst_n) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Load/use: a load in E writes a register that decode is reading now.
    assign lu = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                (bus.E_dstM != R_NONE) &&
                ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    // Jumps are predicted taken, so a not-taken JXX in E was mispredicted.
    assign mp = (bus.E_icode == I_JXX) && !bus.e_Cnd;
    assign rt = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                (bus.M_icode == I_RET);

    always_comb begin
        ctl = CTL_IDLE;
        case (cur_st)
            ST_RUN: begin
                ctl.f_stall  = lu | rt;
                ctl.d_stall  = lu;
                // Load/use wins over ret: decode is held, not flushed.
                ctl.d_bubble = mp | (rt & ~lu);
                ctl.e_bubble = mp | lu;
                ctl.m_bubble = is_exc(bus.m_stat) | is_exc(bus.W_stat);
                ctl.w_stall  = is_exc(bus.W_stat);
                // An exception further down must not change the flags.
                ctl.set_cc   = (bus.E_icode == I_OPQ) &
                               ~is_exc(bus.m_stat) & ~is_exc(bus.W_stat);
            end
            ST_HALTED: ctl = CTL_HALTED;
            default:   ctl = CTL_IDLE;
        endcase
    end

    assign bus.F_stall  = ctl.f_stall;
    assign bus.D_stall  = ctl.d_stall;
    assign bus.D_bubble = ctl.d_bubble;
    assign bus.E_bubble = ctl.e_bubble;
    assign bus.M_bubble = ctl.m_bubble;
    assign bus.W_stall  = ctl.w_stall;
    assign bus.set_cc   = ctl.set_cc;
    assign bus.state    = cur_st;
    assign bus.halted   = (cur_st == ST_HALTED);

    // Counters only move in RUN; the RUN->HALTED cycle is still RUN.
    assign in_run = (cur_st == ST_RUN);

    sat_cnt #(.WIDTH(32)) u_cyc_cnt (
        .clk (clk),
        .clr (!rst_n),
        .en  (in_run),
        .cnt (bus.cyc_cnt)
    );

    sat_cnt #(.WIDTH(32)) u_instr_cnt (
        .clk (clk),
        .clr (!rst_n),
        .en  (in_run && (bus.W_stat == STAT_AOK) && (bus.W_icode != I_NOP) &&
              !ctl.w_stall),
        .cnt (bus.instr_cnt)
    );

    sat_cnt #(.WIDTH(32)) u_lu_cnt (
        .clk (clk),
        .clr (!rst_n),
        .en  (in_run && lu),
        .cnt (bus.lu_cnt)
    );

    sat_cnt #(.WIDTH(32)) u_mp_cnt (
        .clk (clk),
        .clr (!rst_n),
        .en  (in_run && mp),
        .cnt (bus.mp_cnt)
    );

    sat_cnt #(.WIDTH(32)) u_ret_cnt (
        .clk (clk),
        .clr (!rst_n),
        .en  (in_run && rt && !lu),
        .cnt (bus.ret_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed, table-driven bench for pipe_ctrl plus a small
// sat_cnt instance for the saturation boundary.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic       sat_clr = 1'b1;
    logic       sat_en  = 1'b0;
    logic [3:0] sat_val;

    sat_cnt #(.WIDTH(4)) u_sat (
        .clk (clk),
        .clr (sat_clr),
        .en  (sat_en),
        .cnt (sat_val)
    );

    int total = 0;
    int bad   = 0;

    // Control order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
    localparam logic [6:0] C_IDLE   = 7'b1011100;
    localparam logic [6:0] C_HALTED = 7'b1000110;
    localparam logic [6:0] C_NONE   = 7'b0000000;

    typedef struct {
        logic [3:0] d_ic, e_ic, m_ic, w_ic;
        logic [3:0] src_a, src_b, dst_m;
        logic       cnd;
        logic [1:0] m_st;
        logic [6:0] ctl;
        logic [3:0] dlt; // counter increments {instr, lu, mp, ret}
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [3:0] d_ic, e_ic, m_ic, w_ic, src_a, src_b, dst_m,
        input logic cnd, input logic [1:0] m_st,
        input logic [6:0] ctl, input logic [3:0] dlt);
        vec_t v;
        v.d_ic = d_ic; v.e_ic = e_ic; v.m_ic = m_ic; v.w_ic = w_ic;
        v.src_a = src_a; v.src_b = src_b; v.dst_m = dst_m;
        v.cnd = cnd; v.m_st = m_st; v.ctl = ctl; v.dlt = dlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                bus.M_bubble, bus.W_stall, bus.set_cc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        bus.start   = 1'b0;
        bus.D_icode = 4'h1; bus.E_icode = 4'h1;
        bus.M_icode = 4'h1; bus.W_icode = 4'h1;
        bus.d_srcA  = 4'h0; bus.d_srcB  = 4'h0; bus.E_dstM = 4'hF;
        bus.e_Cnd   = 1'b1; bus.m_stat  = 2'd0; bus.W_stat = 2'd0;
    endtask

    task automatic apply(input vec_t v);
        bus.D_icode = v.d_ic; bus.E_icode = v.e_ic;
        bus.M_icode = v.m_ic; bus.W_icode = v.w_ic;
        bus.d_srcA  = v.src_a; bus.d_srcB = v.src_b; bus.E_dstM = v.dst_m;
        bus.e_Cnd   = v.cnd;  bus.m_stat = v.m_st; bus.W_stat = 2'd0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c_cyc, c_ins, c_lu, c_mp, c_ret;

        vecs[0]  = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, C_NONE,     4'b0000);
        vecs[1]  = mk(4'h1, 4'h5, 4'h1, 4'h1, 4'h3, 4'h0, 4'h3, 1, 0, 7'b1101000, 4'b0100);
        vecs[2]  = mk(4'h1, 4'hB, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 1, 0, 7'b1101000, 4'b0100);
        vecs[3]  = mk(4'h1, 4'h5, 4'h1, 4'h1, 4'hF, 4'h0, 4'hF, 1, 0, C_NONE,     4'b0000);
        vecs[4]  = mk(4'h1, 4'h5, 4'h1, 4'h1, 4'h2, 4'h4, 4'h3, 1, 0, C_NONE,     4'b0000);
        vecs[5]  = mk(4'h9, 4'h7, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 0, 0, 7'b1011000, 4'b0011);
        vecs[6]  = mk(4'h1, 4'h7, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, C_NONE,     4'b0000);
        vecs[7]  = mk(4'h9, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 7'b1010000, 4'b0001);
        vecs[8]  = mk(4'h1, 4'h1, 4'h9, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 7'b1010000, 4'b0001);
        vecs[9]  = mk(4'h9, 4'h5, 4'h1, 4'h1, 4'h3, 4'h0, 4'h3, 1, 0, 7'b1101000, 4'b0100);
        vecs[10] = mk(4'h1, 4'h6, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 7'b0000001, 4'b0000);
        vecs[11] = mk(4'h1, 4'h1, 4'h1, 4'h6, 4'h0, 4'h0, 4'hF, 1, 0, C_NONE,     4'b1000);
        vecs[12] = mk(4'h1, 4'h6, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1, 2, 7'b0000100, 4'b0000);
        vecs[13] = mk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 1, 3, 7'b0000100, 4'b1000);
        vecs[14] = mk(4'h1, 4'h7, 4'h9, 4'h1, 4'h0, 4'h0, 4'hF, 0, 0, 7'b1011000, 4'b0011);

        // Reset state.
        set_nop();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst state", 32'(bus.state), 32'd0);
        check("rst halted", 32'(bus.halted), 32'd0);
        check("rst ctl", 32'(ctl_now()), 32'(C_IDLE));
        check("rst cyc", bus.cyc_cnt, 32'd0);
        check("rst instr", bus.instr_cnt, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle stays", 32'(bus.state), 32'd0);
        check("idle cyc frozen", bus.cyc_cnt, 32'd0);

        // Start pulse, then all-NOP run.
        pulse_start();
        check("start state", 32'(bus.state), 32'd1);
        check("start cyc", bus.cyc_cnt, 32'd0);
        #3;
        check("nop ctl", 32'(ctl_now()), 32'(C_NONE));
        tick(); tick(); tick();
        check("nop cyc", bus.cyc_cnt, 32'd3);

        // Table-driven hazard decode and counter increments.
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #3;
            check($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            c_cyc = bus.cyc_cnt; c_ins = bus.instr_cnt;
            c_lu = bus.lu_cnt; c_mp = bus.mp_cnt; c_ret = bus.ret_cnt;
            tick();
            check($sformatf("v%0d cyc", i), bus.cyc_cnt, c_cyc + 32'd1);
            check($sformatf("v%0d instr", i), bus.instr_cnt, c_ins + 32'(vecs[i].dlt[3]));
            check($sformatf("v%0d lu", i), bus.lu_cnt, c_lu + 32'(vecs[i].dlt[2]));
            check($sformatf("v%0d mp", i), bus.mp_cnt, c_mp + 32'(vecs[i].dlt[1]));
            check($sformatf("v%0d ret", i), bus.ret_cnt, c_ret + 32'(vecs[i].dlt[0]));
            check($sformatf("v%0d state", i), 32'(bus.state), 32'd1);
        end
        set_nop();

        // Reset mid-RUN at cyc_cnt == 20.
        for (int k = 0; k < 100 && bus.cyc_cnt != 32'd20; k++) tick();
        check("mid cyc 20", bus.cyc_cnt, 32'd20);
        rst_n = 1'b0;
        #3;
        check("in-reset ctl", 32'(ctl_now()), 32'(C_IDLE));
        check("in-reset halted", 32'(bus.halted), 32'd0);
        tick();
        check("mid rst state", 32'(bus.state), 32'd0);
        check("mid rst cyc", bus.cyc_cnt, 32'd0);
        check("mid rst instr", bus.instr_cnt, 32'd0);
        check("mid rst lu", bus.lu_cnt, 32'd0);
        check("mid rst mp", bus.mp_cnt, 32'd0);
        check("mid rst ret", bus.ret_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        // Exception in M, then in W, then HALTED.
        pulse_start();
        check("restart state", 32'(bus.state), 32'd1);
        bus.E_icode = 4'h6;
        bus.m_stat  = 2'd2;
        #3;
        check("m exc m_bubble", 32'(bus.M_bubble), 32'd1);
        check("m exc set_cc", 32'(bus.set_cc), 32'd0);
        tick();
        bus.m_stat = 2'd0;
        bus.W_stat = 2'd2;
        #3;
        check("w exc ctl", 32'(ctl_now()), 32'b0000110);
        check("w exc state", 32'(bus.state), 32'd1);
        c_cyc = bus.cyc_cnt; c_ins = bus.instr_cnt;
        tick();
        check("halt state", 32'(bus.state), 32'd2);
        check("halt flag", 32'(bus.halted), 32'd1);
        check("halt cyc", bus.cyc_cnt, c_cyc + 32'd1);
        check("halt instr", bus.instr_cnt, c_ins);
        check("halt ctl", 32'(ctl_now()), 32'(C_HALTED));
        c_cyc = bus.cyc_cnt;
        bus.W_stat  = 2'd0;
        bus.start   = 1'b1;
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        bus.D_icode = 4'h9; bus.W_icode = 4'h6;
        tick(); tick(); tick();
        check("frozen state", 32'(bus.state), 32'd2);
        check("frozen cyc", bus.cyc_cnt, c_cyc);
        check("frozen instr", bus.instr_cnt, c_ins);
        check("frozen lu", bus.lu_cnt, 32'd0);
        check("frozen ret", bus.ret_cnt, 32'd0);
        check("frozen ctl", 32'(ctl_now()), 32'(C_HALTED));
        set_nop();

        // Saturation boundary on a narrow counter.
        sat_clr = 1'b1;
        tick();
        check("sat clr", 32'(sat_val), 32'd0);
        sat_clr = 1'b0;
        sat_en  = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        check("sat 14", 32'(sat_val), 32'd14);
        tick();
        check("sat max", 32'(sat_val), 32'd15);
        tick();
        tick();
        check("sat hold", 32'(sat_val), 32'd15);
        sat_clr = 1'b1;
        tick();
        check("sat clr wins", 32'(sat_val), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
